message_stream_splitter: RTL

- Inverse of the message stream combiner: accepts the single combined, header-framed word stream and routes each packet's payload to one of N_STREAMS output streams.
- Sits at the receive side of the message path, e.g. after a serial/debug channel, and restores per-source message streams.
- Headers are consumed, not forwarded. Malformed input raises a sticky error flag.
- No backpressure: one input word per cycle at most, one output word per cycle at most.

---
 rtl/message_stream_splitter.sv | 119 +++++++++++
 1 files changed

// File: rtl/message_stream_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | message_stream_splitter: routes header-framed payloads to N streams.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module message_stream_splitter #(
  parameter int N_STREAMS             = 2,
  parameter int LOG_N_STREAMS         = 1,
  parameter int WIDTH                 = 32,
  parameter int MAX_PACKET_LENGTH     = 16,
  parameter int LOG_MAX_PACKET_LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_nd,
  output logic [WIDTH-1:0]     out_data,
  output logic [N_STREAMS-1:0] out_nd,
  output logic                 error
);

  localparam logic [LOG_N_STREAMS:0]         c_n_streams = (LOG_N_STREAMS+1)'(N_STREAMS);
  localparam logic [LOG_MAX_PACKET_LENGTH:0] c_max_len   = (LOG_MAX_PACKET_LENGTH+1)'(MAX_PACKET_LENGTH);
  localparam logic [LOG_MAX_PACKET_LENGTH-1:0] c_len_one = LOG_MAX_PACKET_LENGTH'(1);
  localparam logic [N_STREAMS-1:0]           c_nd_one    = N_STREAMS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                           r_state, w_state_next;
  logic [LOG_MAX_PACKET_LENGTH-1:0] r_remaining, w_remaining_next;
  logic [LOG_N_STREAMS-1:0]         r_stream, w_stream_next;
  logic [WIDTH-1:0]                 r_out_data;
  logic [N_STREAMS-1:0]             r_out_nd;
  logic                             r_error;
  logic                             w_err_set;
  logic                             w_emit;

  logic                             w_flag;
  logic [LOG_MAX_PACKET_LENGTH-1:0] w_len;
  logic [LOG_N_STREAMS-1:0]         w_sid;
  logic                             w_sid_ok;
  logic                             w_len_ok;
  logic                             w_last;

  assign w_flag   = in_data[WIDTH-1];
  assign w_len    = in_data[LOG_MAX_PACKET_LENGTH-1:0];
  assign w_sid    = in_data[LOG_MAX_PACKET_LENGTH+LOG_N_STREAMS-1:LOG_MAX_PACKET_LENGTH];
  assign w_sid_ok = ({1'b0, w_sid} < c_n_streams);
  assign w_len_ok = ({1'b0, w_len} <= c_max_len);
  assign w_last   = (r_remaining == c_len_one);

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_stream_next    = r_stream;
    w_err_set        = 1'b0;
    w_emit           = 1'b0;
    if (in_nd) begin
      case (r_state)
        IDLE: begin
          if (!w_flag) begin
            w_err_set = 1'b1;
          end else if (w_len == '0) begin
            // Empty packet: legal only when the stream id is in range.
            w_err_set = !w_sid_ok;
          end else if (w_sid_ok && w_len_ok) begin
            w_stream_next    = w_sid;
            w_remaining_next = w_len;
            w_state_next     = PAYLOAD;
          end else begin
            w_err_set        = 1'b1;
            w_remaining_next = w_len;
            w_state_next     = DISCARD;
          end
        end
        PAYLOAD: begin
          w_emit           = 1'b1;
          w_remaining_next = r_remaining - c_len_one;
          if (w_last) w_state_next = IDLE;
        end
        DISCARD: begin
          w_remaining_next = r_remaining - c_len_one;
          if (w_last) w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_stream    <= '0;
      r_out_data  <= '0;
      r_out_nd    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_stream    <= w_stream_next;
      r_out_nd    <= w_emit ? (c_nd_one << r_stream) : '0;
      if (w_emit) r_out_data <= in_data;
      if (w_err_set) r_error <= 1'b1;
    end
  end

  assign out_data = r_out_data;
  assign out_nd   = r_out_nd;
  assign error    = r_error;

endmodule
`default_nettype wire
